// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampled UART datapath.
// Used by both the transmitter and the receiver path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic LINE_IDLE = 1'b1;

  function automatic int frame_len(
    input int data_bits,
    input int parity_en,
    input int stop_bits
  );
    return 1 + data_bits + parity_en + stop_bits;
  endfunction

endpackage

// File: rtl/osf_tick_divider.sv
// Divides the oversample Tick into bit periods of OSF pulses.
// BitEnd marks the Tick that closes the current bit.
module osf_tick_divider #(
  parameter int OSF = 8
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Clear,
  input  logic Tick,
  output logic BitEnd
);

  localparam int CW = $clog2(OSF);

  logic [CW-1:0] cnt_q;
  logic          at_top;

  assign at_top = (cnt_q == CW'(OSF - 1));
  assign BitEnd = Tick && at_top;

  always_ff @(posedge Clk) begin
    if (Reset || Clear) begin
      cnt_q <= '0;
    end else if (Tick) begin
      cnt_q <= at_top ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_osf.sv
// UART transmitter timed by a shared oversample Tick.
// Frames start, data LSB first, optional parity and stop bits.
module uart_tx_osf
  import uart_pkg::*;
#(
  parameter int OSF        = 8,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Tick,
  input  logic                 TxStart,
  input  logic [DATA_BITS-1:0] TxData,
  output logic                 Tx,
  output logic                 Busy,
  output logic                 Done
);

  localparam int IW = 4;

  tx_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 par_q, par_d;
  logic                 tx_d, busy_d, done_d;
  logic                 accept;
  logic                 bit_end;

  assign accept = (state_q == IDLE) && TxStart;

  osf_tick_divider #(
    .OSF(OSF)
  ) u_div (
    .Clk   (Clk),
    .Reset (Reset),
    .Clear (accept),
    .Tick  (Tick),
    .BitEnd(bit_end)
  );

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    idx_d   = idx_q;
    par_d   = par_q;
    done_d  = 1'b0;
    tx_d    = LINE_IDLE;
    busy_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (TxStart) begin
          state_d = START;
          sh_d    = TxData;
          idx_d   = '0;
          par_d   = (^TxData) ^ (PARITY_ODD != 0);
        end
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end) begin
          sh_d = sh_q >> 1;
          if (idx_q == IW'(DATA_BITS - 1)) begin
            idx_d   = '0;
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (bit_end) begin
          if (idx_q == IW'(STOP_BITS - 1)) begin
            idx_d   = '0;
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Line level follows the next state so Tx stays registered.
    unique case (state_d)
      IDLE:    tx_d = LINE_IDLE;
      START:   tx_d = 1'b0;
      DATA:    tx_d = sh_d[0];
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      sh_q    <= '0;
      idx_q   <= '0;
      par_q   <= 1'b0;
      Tx      <= LINE_IDLE;
      Busy    <= 1'b0;
      Done    <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      idx_q   <= idx_d;
      par_q   <= par_d;
      Tx      <= tx_d;
      Busy    <= busy_d;
      Done    <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_osf.sv
// Directed bench for uart_tx_osf across five parameter sets.
// Expected line levels are built from hand-written frame vectors.
module tb_uart_tx_osf;
  import uart_pkg::*;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Tick = 1'b1;
  logic [8:0] data = '0;
  logic [4:0] st = '0;
  logic [4:0] tx, busy, done;
  bit         sparse = 1'b0;
  int         ph = 0;
  int         checks = 0;
  int         errors = 0;

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (sparse) begin
      ph = (ph + 1) % 4;
      Tick = (ph == 0);
    end else begin
      Tick = 1'b1;
    end
  end

  uart_tx_osf u0 (
    .Clk(Clk), .Reset(Reset), .Tick(Tick),
    .TxStart(st[0]), .TxData(data[7:0]),
    .Tx(tx[0]), .Busy(busy[0]), .Done(done[0])
  );

  uart_tx_osf #(.PARITY_EN(1), .PARITY_ODD(0)) u1 (
    .Clk(Clk), .Reset(Reset), .Tick(Tick),
    .TxStart(st[1]), .TxData(data[7:0]),
    .Tx(tx[1]), .Busy(busy[1]), .Done(done[1])
  );

  uart_tx_osf #(.PARITY_EN(1), .PARITY_ODD(1)) u2 (
    .Clk(Clk), .Reset(Reset), .Tick(Tick),
    .TxStart(st[2]), .TxData(data[7:0]),
    .Tx(tx[2]), .Busy(busy[2]), .Done(done[2])
  );

  uart_tx_osf #(.STOP_BITS(2)) u3 (
    .Clk(Clk), .Reset(Reset), .Tick(Tick),
    .TxStart(st[3]), .TxData(data[7:0]),
    .Tx(tx[3]), .Busy(busy[3]), .Done(done[3])
  );

  uart_tx_osf #(.DATA_BITS(9)) u4 (
    .Clk(Clk), .Reset(Reset), .Tick(Tick),
    .TxStart(st[4]), .TxData(data),
    .Tx(tx[4]), .Busy(busy[4]), .Done(done[4])
  );

  task automatic chk(input string tag, input logic [2:0] obs,
                     input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // bits[i] is the level of frame bit i; each bit spans 8 Ticks.
  task automatic send(input int s, input logic [15:0] bits,
                      input int nb, input bit hold,
                      input logic [8:0] nxt);
    int t;
    int cyc;
    logic [2:0] exp;
    st[s] = 1'b1;
    @(posedge Clk);
    #1;
    chk("accept", {tx[s], busy[s], done[s]}, 3'b010);
    data = nxt;
    if (!hold) st[s] = 1'b0;
    t = 0;
    cyc = 0;
    while (t < 8 * nb && cyc < 2000) begin
      @(posedge Clk);
      cyc++;
      if (Tick) t++;
      #1;
      if (t == 8 * nb) exp = 3'b101;
      else exp = {bits[t/8], 2'b10};
      chk("frame", {tx[s], busy[s], done[s]}, exp);
    end
    checks++;
    assert (t == 8 * nb) else begin
      errors++;
      $error("FAIL timeout observed=%0d expected=%0d", t, 8 * nb);
    end
  endtask

  task automatic idle_chk(input int s);
    @(posedge Clk);
    #1;
    chk("idle", {tx[s], busy[s], done[s]}, 3'b100);
  endtask

  initial begin
    repeat (3) @(posedge Clk);
    #1;
    for (int i = 0; i < 5; i++)
      chk("reset", {tx[i], busy[i], done[i]}, 3'b100);
    Reset = 1'b0;
    @(posedge Clk);
    #1;

    // 8N1, 0x55
    data = 9'h055;
    send(0, 16'({1'b1, 8'h55, 1'b0}), 10, 1'b0, 9'h000);
    idle_chk(0);
    checks++;
    assert (frame_len(8, 0, 1) == 10) else begin
      errors++;
      $error("FAIL flen observed=%0d expected=10", frame_len(8, 0, 1));
    end

    // even parity of 0x07 is 1, odd is 0
    data = 9'h007;
    send(1, 16'({1'b1, 1'b1, 8'h07, 1'b0}), 11, 1'b0, 9'h000);
    idle_chk(1);
    data = 9'h007;
    send(2, 16'({1'b1, 1'b0, 8'h07, 1'b0}), 11, 1'b0, 9'h000);
    idle_chk(2);

    // sparse Tick, two stop bits
    sparse = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    data = 9'h0A3;
    send(3, 16'({2'b11, 8'hA3, 1'b0}), 11, 1'b0, 9'h000);
    idle_chk(3);
    sparse = 1'b0;
    repeat (2) @(posedge Clk);
    #1;

    // back-to-back with TxStart held high
    data = 9'h0FF;
    send(0, 16'({1'b1, 8'hFF, 1'b0}), 10, 1'b1, 9'h000);
    send(0, 16'({1'b1, 8'h00, 1'b0}), 10, 1'b0, 9'h000);
    idle_chk(0);

    // reset during data bit 3
    data = 9'h000;
    st[0] = 1'b1;
    @(posedge Clk);
    #1;
    st[0] = 1'b0;
    repeat (34) @(posedge Clk);
    #1;
    chk("bit3", {tx[0], busy[0], done[0]}, 3'b010);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    chk("abort", {tx[0], busy[0], done[0]}, 3'b100);
    Reset = 1'b0;
    idle_chk(0);
    data = 9'h000;
    send(0, 16'({1'b1, 8'h00, 1'b0}), 10, 1'b0, 9'h000);
    idle_chk(0);

    // nine data bits
    data = 9'h1FF;
    send(4, 16'({1'b1, 9'h1FF, 1'b0}), 11, 1'b0, 9'h000);
    idle_chk(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_osf.md
Name: uart_tx_osf

Overview:
- Serial transmitter that pairs with the oversampling receiver path.
- Frames a parallel word as start, data (LSB first), optional parity, then stop bit(s), and drives one line (Tx).
- Bit timing comes from an external oversample enable (Tick, OSF pulses per bit), so transmitter and receiver share one baud/oversample generator.
- Sits between the datapath word source and the FPGA pin.

Parameters:
- OSF, 8, Tick pulses per bit period; must be >= 2.
- DATA_BITS, 8, data bits per frame; range 5..9.
- PARITY_EN, 0, 1 inserts one parity bit after the data bits.
- PARITY_ODD, 0, parity sense when PARITY_EN=1: 0 = even, 1 = odd.
- STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
- Clk  input  1  system clock, all logic on posedge.
- Reset  input  1  synchronous, active-high.
- Tick  input  1  oversample enable, one-cycle pulse at OSF x baud rate.
- TxStart  input  1  request to send TxData.
- TxData  input  DATA_BITS  word to send; sampled only on acceptance.
- Tx  output  1  serial line; idles high.
- Busy  output  1  high while a frame is in progress.
- Done  output  1  one-cycle pulse when the last stop bit completes.

Behaviour:
- Reset (Clk edge with Reset=1):
  - Tx=1, Busy=0, Done=0.
  - State IDLE; tick counter, bit index and shift register cleared.
  - Reset mid-frame aborts the frame at that edge; Tx returns high with no partial stop bit.
- States and transitions:
  - IDLE -> START on acceptance.
  - START -> DATA.
  - DATA -> PARITY if PARITY_EN, else -> STOP.
  - PARITY -> STOP.
  - STOP -> IDLE.
- Acceptance:
  - Occurs on an edge where state is IDLE and TxStart=1.
  - TxData is latched into the shift register, the parity bit is computed from the latched word, and the tick counter is cleared.
  - Tx=0 and Busy=1 from that edge.
  - Tick is not required at the acceptance edge.
- TxStart while Busy=1 is ignored; there is no queueing. TxData may change freely after acceptance.
- Tick counter:
  - Counts 0..OSF-1 and advances only on Tick=1.
  - On Tick=1 with the counter at OSF-1: counter wraps to 0 and the current bit ends.
  - Each bit therefore lasts exactly OSF Tick pulses after it starts.
- Bit order:
  - START drives 0.
  - DATA drives shift-register bit 0; the register shifts right at each bit end; DATA_BITS bits are sent.
  - PARITY drives the XOR of the data bits when PARITY_EN=1 and PARITY_ODD=0; when PARITY_ODD=1 it drives the inverted XOR.
  - STOP drives 1 for STOP_BITS bit periods.
- Frame length: N = 1 + DATA_BITS + PARITY_EN + STOP_BITS bits, i.e. OSF*N Tick pulses from acceptance.
- End of frame:
  - At the edge ending the final stop bit: state goes to IDLE, Busy=0, Done=1 for exactly one cycle, Tx stays 1.
  - Back-to-back: TxStart=1 in the cycle Done=1 is accepted at the next edge, giving an idle gap of 0 bit periods.
- Outputs: Tx, Busy and Done are registered, with no combinational path from inputs.
- Tick held high continuously is legal; the bit period is then OSF clocks.

Decomposition:
- Package uart_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - the frame-length function N(DATA_BITS, PARITY_EN, STOP_BITS);
  - the line idle level constant (1).
- One sub-module, osf_tick_divider:
  - counts Tick up to OSF and emits a one-cycle BitEnd pulse;
  - has a synchronous clear used at acceptance;
  - is reusable by the receiver path.
- Top level holds the FSM, shift register, bit index and parity logic.

Test Plan:
- Idle/reset: OSF=8, Tick=1 constant, TxData=0x55, TxStart pulsed once -> Tx sequence 0,1,0,1,0,1,0,1,0,1, each level held 8 clocks; Done after exactly 80 clocks; Busy high 80 clocks.
- Parity: PARITY_EN=1, PARITY_ODD=0, TxData=0x07 -> parity bit 1, frame 88 ticks. Same with PARITY_ODD=1 -> parity bit 0.
- Sparse Tick: Tick every 4th clock, OSF=8, TxData=0xA3, STOP_BITS=2 -> each bit lasts 32 clocks; two stop periods high; Done after 11*32 clocks (+/-3 by Tick phase).
- Back-to-back and ignore: TxStart held high continuously with TxData=0xFF then 0x00 -> second frame's start bit begins the cycle after Done; no third frame accepted mid-frame; no gap between frames.
- Reset mid-frame: assert Reset during data bit 3 of 0x00 -> Tx=1, Busy=0, Done=0 next edge. New TxStart then sends a complete frame.
- Width: DATA_BITS=9, TxData=0x1FF -> 9 ones after start, frame 11 bits, Done once.
